// File: rtl/wos_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wos_mem_pkg
//  Description : Shared constants for the WOS data-memory controller.
//                Holds the RISC-V load/store width codes, the word offsets
//                of the config bank, the mask sizing helper and the
//                split-access FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package wos_mem_pkg;

  // RISC-V funct3 width/sign codes (stores use the same low two bits)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Config bank word offsets relative to CFG_BASE
  localparam int CFG_PARAMS = 0;
  localparam int CFG_MASK0  = 1;

  // Number of 32-bit words needed to hold a max_n x max_n mask
  function automatic int mask_words(input int max_n);
    return (max_n * max_n + 31) / 32;
  endfunction

  function automatic int cfg_commit(input int max_n);
    return mask_words(max_n) + 1;
  endfunction

  function automatic int cfg_status(input int max_n);
    return mask_words(max_n) + 2;
  endfunction

  // Split-access FSM
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/wos_cfg_regs.sv
`default_nettype none
// ============================================================================
//  Module      : wos_cfg_regs
//  Description : Double-buffered WOS filter config bank. Software writes the
//                shadow PARAMS/MASK words; a COMMIT write copies shadow into
//                the active registers, deferred while the filter is mid-frame.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                i_wr            accepted, well-formed config store
//                i_idx           config word index
//                i_wdata         store data
//                i_busy          filter mid-frame, defers commit
//                o_rdata         shadow/status read data for i_idx (comb.)
//                o_params/o_mask active configuration
//                o_pending       commit requested but not yet applied
//  Revision    : 1.0  initial release
// ============================================================================
module wos_cfg_regs
  import wos_mem_pkg::*;
#(
  parameter int MAX_N = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr,
  input  logic [31:0]            i_idx,
  input  logic [31:0]            i_wdata,
  input  logic                   i_busy,
  output logic [31:0]            o_rdata,
  output logic [31:0]            o_params,
  output logic [MAX_N*MAX_N-1:0] o_mask,
  output logic                   o_pending
);

  localparam int          MASK_BITS  = MAX_N * MAX_N;
  localparam logic [31:0] IDX_PARAMS = 32'(CFG_PARAMS);
  localparam logic [31:0] IDX_MASK0  = 32'(CFG_MASK0);
  localparam logic [31:0] IDX_COMMIT = 32'(cfg_commit(MAX_N));
  localparam logic [31:0] IDX_STATUS = 32'(cfg_status(MAX_N));

  logic [31:0]          sh_params_q, act_params_q;
  logic [MASK_BITS-1:0] sh_mask_q, sh_mask_d, act_mask_q;
  logic                 pending_q, pending_d;
  logic                 commit_req, apply;

  always_comb begin
    commit_req = i_wr && (i_idx == IDX_COMMIT);
    // A deferred commit fires on the first cycle the filter is idle
    apply      = (commit_req || pending_q) && !i_busy;
    if (apply)           pending_d = 1'b0;
    else if (commit_req) pending_d = 1'b1;
    else                 pending_d = pending_q;

    // Mask bit b lives in mask word b/32, bit b%32
    sh_mask_d = sh_mask_q;
    for (int b = 0; b < MASK_BITS; b++) begin
      if (i_wr && (i_idx == IDX_MASK0 + 32'(b / 32))) begin
        sh_mask_d[b] = i_wdata[b % 32];
      end
    end

    // Reads see the shadow copy; unused mask bits and holes read as 0
    o_rdata = '0;
    if (i_idx == IDX_PARAMS) o_rdata = sh_params_q;
    if (i_idx == IDX_STATUS) o_rdata = {31'h0, pending_q};
    for (int b = 0; b < MASK_BITS; b++) begin
      if (i_idx == IDX_MASK0 + 32'(b / 32)) begin
        o_rdata[b % 32] = sh_mask_q[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_params_q  <= '0;
      act_params_q <= '0;
      sh_mask_q    <= '0;
      act_mask_q   <= '0;
      pending_q    <= 1'b0;
    end else begin
      if (i_wr && (i_idx == IDX_PARAMS)) sh_params_q <= i_wdata;
      sh_mask_q <= sh_mask_d;
      // Non-blocking copy: a shadow write on the apply cycle is not seen
      if (apply) begin
        act_params_q <= sh_params_q;
        act_mask_q   <= sh_mask_q;
      end
      pending_q <= pending_d;
    end
  end

  assign o_params  = act_params_q;
  assign o_mask    = act_mask_q;
  assign o_pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/wos_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wos_dmem_ctrl
//  Description : RISC-V MEM-stage data memory controller. Byte-strobed word
//                RAM plus memory-mapped double-buffered WOS config bank.
//                Word-crossing accesses take two RAM cycles with one stall.
//  Options     : WOS_DMEM_ACCESS_FAULT_EN - adds o_fault; out-of-map or
//                malformed config accesses pulse o_fault, writes dropped,
//                loads return 0.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                i_req/i_we        request, 1=store
//                i_addr/i_wdata    byte address, LSB-aligned store data
//                i_func3           RISC-V width/sign code
//                i_filter_busy     filter mid-frame, defers commit
//                o_stall           first half of split access
//                o_rvalid/o_rdata  load result, extended per func3
//                o_params/o_mask   active filter configuration
//                o_cfg_pending     commit waiting for filter idle
//                o_fault           access fault pulse (option only)
//  Revision    : 1.0  initial release
// ============================================================================
module wos_dmem_ctrl
  import wos_mem_pkg::*;
#(
  parameter int          MEM_BYTES = 1024,
  parameter int          MAX_N     = 5,
  parameter logic [31:0] CFG_BASE  = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic                   i_we,
  input  logic [31:0]            i_addr,
  input  logic [31:0]            i_wdata,
  input  logic [2:0]             i_func3,
  input  logic                   i_filter_busy,
  output logic                   o_stall,
  output logic                   o_rvalid,
  output logic [31:0]            o_rdata,
  output logic [31:0]            o_params,
  output logic [MAX_N*MAX_N-1:0] o_mask,
  output logic                   o_cfg_pending
`ifdef WOS_DMEM_ACCESS_FAULT_EN
  ,
  output logic                   o_fault
`endif
);

  localparam int          AW         = $clog2(MEM_BYTES);
  localparam int          WW         = AW - 2;
  localparam int          MEM_WORDS  = MEM_BYTES / 4;
  localparam logic [31:0] IDX_STATUS = 32'(cfg_status(MAX_N));

  logic [31:0]  mem [MEM_WORDS];

  dmem_state_e  state_q, state_d;
  logic         second, is_cfg, cfg_ok, ram_ok, crossing, accept, cfg_wr;
  logic [31:0]  cfg_idx, cfg_rdata, mem_rd, lo_q, rd_shift, ext, load_val;
  logic [3:0]   base_strb, wr_strb;
  logic [7:0]   strb8;
  logic [63:0]  wdata64, rd_pair;
  logic [31:0]  wr_word;
  logic [WW-1:0] widx_cur;
  logic         rvalid_q;
  logic [31:0]  rdata_q;

  always_comb begin
    second  = (state_q == ST_SECOND);
    is_cfg  = (i_addr >= CFG_BASE);
    cfg_idx = (i_addr - CFG_BASE) >> 2;
    cfg_ok  = is_cfg && (i_func3 == F3_W) && (i_addr[1:0] == 2'b00) &&
              (cfg_idx <= IDX_STATUS);
`ifdef WOS_DMEM_ACCESS_FAULT_EN
    ram_ok  = (i_addr < 32'(MEM_BYTES));
`else
    ram_ok  = !is_cfg;
`endif
    crossing = ram_ok &&
               (((i_func3 == F3_W) && (i_addr[1:0] != 2'b00)) ||
                (((i_func3 == F3_H) || (i_func3 == F3_HU)) && (i_addr[1:0] == 2'b11)));
    o_stall = !second && i_req && crossing;
    accept  = i_req && !o_stall;
    cfg_wr  = accept && i_we && cfg_ok && !rst;

    // 8-lane strobe/data view spanning this word and the next one
    case (i_func3[1:0])
      2'b00:   base_strb = 4'b0001;
      2'b01:   base_strb = 4'b0011;
      2'b10:   base_strb = 4'b1111;
      default: base_strb = 4'b0000;
    endcase
    strb8    = {4'b0000, base_strb} << i_addr[1:0];
    wdata64  = {32'h0, i_wdata} << {i_addr[1:0], 3'b000};
    wr_strb  = second ? strb8[7:4] : strb8[3:0];
    wr_word  = second ? wdata64[63:32] : wdata64[31:0];
    // Second half targets the next word; the narrow index wraps the RAM
    widx_cur = i_addr[AW-1:2] + WW'(second);
    mem_rd   = mem[widx_cur];

    rd_pair  = {mem_rd, second ? lo_q : mem_rd};
    rd_shift = 32'(rd_pair >> {i_addr[1:0], 3'b000});
    case (i_func3)
      F3_B:    ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3_H:    ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_W:    ext = rd_shift;
      F3_BU:   ext = {24'h0, rd_shift[7:0]};
      F3_HU:   ext = {16'h0, rd_shift[15:0]};
      default: ext = '0;
    endcase
    load_val = ram_ok ? ext : (cfg_ok ? cfg_rdata : 32'h0);

    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (o_stall) state_d = ST_SECOND;
      ST_SECOND: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // RAM is not reset; rst still blocks the pending half of a split store
  always_ff @(posedge clk) begin
    if (i_req && i_we && ram_ok && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[widx_cur][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lo_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      if (!second) lo_q <= mem_rd;
      rvalid_q <= accept && !i_we;
      if (accept && !i_we) rdata_q <= load_val;
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;

`ifdef WOS_DMEM_ACCESS_FAULT_EN
  logic fault_q;
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= accept && !ram_ok && !cfg_ok;
  end
  assign o_fault = fault_q;
`endif

  wos_cfg_regs #(
    .MAX_N (MAX_N)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (cfg_wr),
    .i_idx     (cfg_idx),
    .i_wdata   (i_wdata),
    .i_busy    (i_filter_busy),
    .o_rdata   (cfg_rdata),
    .o_params  (o_params),
    .o_mask    (o_mask),
    .o_pending (o_cfg_pending)
  );

endmodule
`default_nettype wire

// File: tb/tb_wos_dmem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wos_dmem_ctrl
//  Description : Self-checking bench for wos_dmem_ctrl. A byte-level memory
//                image and a shadow/active/pending config model predict every
//                load result, stall, fault and active configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wos_dmem_ctrl;

  localparam int          MEM_BYTES = 1024;
  localparam logic [31:0] CFG_BASE  = 32'h8000_0000;
  localparam logic [2:0]  LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;

  logic        clk = 1'b0;
  logic        rst, i_req, i_we, busy;
  logic [31:0] i_addr, i_wdata;
  logic [2:0]  i_func3;
  logic        o_stall, o_rvalid, o_cfg_pending;
  logic [31:0] o_rdata, o_params;
  logic [24:0] o_mask;
`ifdef WOS_DMEM_ACCESS_FAULT_EN
  logic        o_fault;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0]  m_mem [MEM_BYTES];
  logic [31:0] m_shp, m_actp;
  logic [24:0] m_shm, m_actm;
  logic        m_pend, exp_fault;

  always #5 clk = ~clk;

  wos_dmem_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (i_req),
    .i_we          (i_we),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .i_func3       (i_func3),
    .i_filter_busy (busy),
    .o_stall       (o_stall),
    .o_rvalid      (o_rvalid),
    .o_rdata       (o_rdata),
    .o_params      (o_params),
    .o_mask        (o_mask),
    .o_cfg_pending (o_cfg_pending)
`ifdef WOS_DMEM_ACCESS_FAULT_EN
    ,
    .o_fault       (o_fault)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] fn);
    case (fn[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit in_ram(input logic [31:0] a);
`ifdef WOS_DMEM_ACCESS_FAULT_EN
    return a < 32'(MEM_BYTES);
`else
    return a < CFG_BASE;
`endif
  endfunction

  function automatic bit cfg_valid(input logic [31:0] a, input logic [2:0] fn);
    return (a >= CFG_BASE) && (fn == LW) && (a % 4 == 0) && ((a - CFG_BASE) / 4 <= 3);
  endfunction

  function automatic bit splits(input logic [31:0] a, input logic [2:0] fn);
    return in_ram(a) && ((a % 4) + 32'(size_of(fn)) > 4);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] fn);
    logic [31:0] v;
    int sz;
    v  = 0;
    sz = size_of(fn);
    if (in_ram(a)) begin
      for (int i = 0; i < sz; i++)
        v = v | (32'(m_mem[int'((a + 32'(i)) % MEM_BYTES)]) << (8 * i));
      if (fn == LB && v >= 32'h80)   v = v | 32'hFFFF_FF00;
      if (fn == LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    if (cfg_valid(a, fn)) begin
      case ((a - CFG_BASE) / 4)
        0:       return m_shp;
        1:       return 32'(m_shm);
        3:       return 32'(m_pend);
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_shp = 0; m_actp = 0; m_shm = 0; m_actm = 0; m_pend = 0; exp_fault = 0;
  endtask

  // Advance the model over one rising edge with the inputs currently driven
  task automatic step(input bit acc);
    bit creq, apply;
    logic [31:0] idx;
    idx = (i_addr - CFG_BASE) / 4;
    if (rst) begin
      model_reset();
    end else begin
      creq  = acc && i_req && i_we && cfg_valid(i_addr, i_func3) && idx == 2;
      apply = (creq || m_pend) && !busy;
      if (apply) begin m_actp = m_shp; m_actm = m_shm; end
      if (acc && i_we) begin
        if (in_ram(i_addr)) begin
          for (int i = 0; i < size_of(i_func3); i++)
            m_mem[int'((i_addr + 32'(i)) % MEM_BYTES)] = 8'(i_wdata >> (8 * i));
        end else if (cfg_valid(i_addr, i_func3)) begin
          if (idx == 0) m_shp = i_wdata;
          if (idx == 1) m_shm = 25'(i_wdata);
        end
      end
      if (apply)     m_pend = 1'b0;
      else if (creq) m_pend = 1'b1;
      exp_fault = acc && i_req && !in_ram(i_addr) && !cfg_valid(i_addr, i_func3);
    end
    @(posedge clk);
  endtask

  task automatic check_cfg();
    check("params", o_params, m_actp);
    check("mask", 32'(o_mask), 32'(m_actm));
    check("pending", 32'(o_cfg_pending), 32'(m_pend));
  endtask

  // Called and returns at a falling edge
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] fn, output logic [31:0] rd);
    bit sp;
    logic [31:0] exp_rd;
    i_req = 1'b1; i_we = we; i_addr = a; i_wdata = wd; i_func3 = fn;
    sp     = splits(a, fn);
    exp_rd = model_load(a, fn);
    #1;
    check("stall_first", 32'(o_stall), 32'(sp));
    if (sp) begin
      step(1'b0);
      @(negedge clk);
      check("stall_second", 32'(o_stall), 0);
      check("rvalid_mid", 32'(o_rvalid), 0);
    end
    step(1'b1);
    @(negedge clk);
    i_req = 1'b0; i_we = 1'b0;
    check("rvalid", 32'(o_rvalid), 32'(!we));
    if (!we) check("rdata", o_rdata, exp_rd);
    rd = o_rdata;
`ifdef WOS_DMEM_ACCESS_FAULT_EN
    check("fault", 32'(o_fault), 32'(exp_fault));
`endif
    check_cfg();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step(1'b0);
      @(negedge clk);
      check_cfg();
    end
  endtask

  function automatic logic [2:0] pick_f3(input bit we);
    int r;
    r = we ? $urandom_range(0, 2) : $urandom_range(0, 4);
    case (r)
      0: return LB;
      1: return LH;
      2: return LW;
      3: return LBU;
      default: return LHU;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, w0;
    rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = 0; i_wdata = 0; i_func3 = 0; busy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", 32'(o_rvalid), 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_stall", 32'(o_stall), 0);
    check("rst_params", o_params, 0);
    check("rst_mask", 32'(o_mask), 0);
    check("rst_pending", 32'(o_cfg_pending), 0);
`ifdef WOS_DMEM_ACCESS_FAULT_EN
    check("rst_fault", 32'(o_fault), 0);
`endif
    rst = 1'b0;

    // give every RAM byte a known value
    for (int w = 0; w < MEM_BYTES / 4; w++) access(1'b1, 32'(w * 4), $urandom, LW, rd);

    // aligned store/load, no stall
    access(1'b1, 32'h10, 32'hDEAD_BEEF, LW, rd);
    access(1'b0, 32'h10, 0, LW, rd);
    check("t1_lw", rd, 32'hDEAD_BEEF);

    // crossing loads: bytes 0..7 = 44 33 22 11 88 77 66 55
    access(1'b1, 32'h0, 32'h1122_3344, LW, rd);
    access(1'b1, 32'h4, 32'h5566_7788, LW, rd);
    access(1'b0, 32'h2, 0, LW, rd);
    check("t2_lw2", rd, 32'h7788_1122);
    access(1'b0, 32'h3, 0, LH, rd);   // bytes 3,4 = 11,88 -> sign-extended 0x8811
    check("t2_lh3", rd, 32'hFFFF_8811);
    access(1'b0, 32'h7, 0, LB, rd);
    check("t2_lb7", rd, 32'h0000_0055);
    access(1'b0, 32'h4, 0, LBU, rd);
    check("t2_lbu4", rd, 32'h0000_0088);

    // deferred commit of the mask
    access(1'b1, CFG_BASE + 4, 32'h01FF_FFFF, LW, rd);
    busy = 1'b1;
    access(1'b1, CFG_BASE + 8, 32'h0, LW, rd);
    check("t3_mask_hold", 32'(o_mask), 0);
    check("t3_pend", 32'(o_cfg_pending), 1);
    idle(2);
    busy = 1'b0;
    idle(1);
    check("t3_mask_new", 32'(o_mask), 32'h01FF_FFFF);
    check("t3_pend_clr", 32'(o_cfg_pending), 0);
    access(1'b0, CFG_BASE + 12, 0, LW, rd);
    check("t3_status", rd, 0);

    // shadow write on the cycle a deferred commit applies
    access(1'b1, CFG_BASE, 32'h5A, LW, rd);
    busy = 1'b1;
    access(1'b1, CFG_BASE + 8, 32'h0, LW, rd);
    access(1'b0, CFG_BASE + 12, 0, LW, rd);
    check("t4_status", rd, 1);
    busy = 1'b0;
    access(1'b1, CFG_BASE, 32'hA5, LW, rd);
    check("t4_old", o_params, 32'h5A);
    access(1'b1, CFG_BASE + 8, 32'h0, LW, rd);
    check("t4_new", o_params, 32'hA5);

    // wrap at top of RAM, and reset during the second half
    access(1'b0, 32'h3FE, 0, LW, rd);
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h3FE; i_wdata = 32'hCAFE_F00D; i_func3 = LW;
    #1 check("t5_stall", 32'(o_stall), 1);
    step(1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0; i_we = 1'b0;
    check("t5_no_rvalid_st", 32'(o_rvalid), 0);
    m_mem[32'h3FE] = 8'h0D;
    m_mem[32'h3FF] = 8'hF0;
    check_cfg();
    i_req = 1'b1; i_addr = 32'h3FE; i_func3 = LW;
    #1 check("t5_stall_ld", 32'(o_stall), 1);
    step(1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0;
    check("t5_no_rvalid_ld", 32'(o_rvalid), 0);
    access(1'b0, 32'h3FE, 0, LW, rd);
    check("t5_lo_half", rd & 32'hFFFF, 32'hF00D);

    // store just past the RAM
    access(1'b0, 32'h0, 0, LW, w0);
    access(1'b1, 32'h400, 32'h1234_5678, LW, rd);
    access(1'b0, 32'h0, 0, LW, rd);
`ifdef WOS_DMEM_ACCESS_FAULT_EN
    check("t6_word0", rd, w0);
`else
    check("t6_word0", rd, 32'h1234_5678);
`endif

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      bit we;
      logic [31:0] a;
      logic [2:0] fn;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7) begin
        a  = 32'($urandom_range(0, 2047));
        fn = pick_f3(we);
      end else begin
        a  = CFG_BASE + 32'($urandom_range(0, 23));
        fn = ($urandom_range(0, 3) != 0) ? LW : 3'($urandom_range(0, 5));
        if (!(a % 4 == 0)) fn = ($urandom_range(0, 1) != 0) ? LW : fn;
      end
      busy = ($urandom_range(0, 3) == 0);
      access(we, a, $urandom, fn, rd);
      if ($urandom_range(0, 4) == 0) begin
        busy = 1'($urandom_range(0, 1));
        idle(1);
      end
    end
    busy = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
